rcn_uart_tx_byte: RTL

RCN_UART_TX_BYTE -- requirements
Module: rcn_uart_tx_byte

---
 rtl/rcn_uart_pkg.sv | 15 +
 rtl/rcn_baud_tick.sv | 25 ++
 rtl/rcn_uart_tx_byte.sv | 104 ++++++++++
 3 files changed

// File: rtl/rcn_uart_pkg.sv
// Shared RCN UART definitions: line-state encodings and frame geometry,
// common to the byte transmitter and the future byte receiver.
package rcn_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/rcn_baud_tick.sv
// Loadable bit-period down-counter. tick marks the last cycle of a bit;
// the counter reloads from value on that cycle or on an explicit load.
module rcn_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == '0);

  // Count down within a bit, reload at each bit boundary, park at zero when idle.
  always_ff @(posedge clk) begin
    if (rst || (!run && !load)) cnt <= '0;
    else if (load || cnt == '0) cnt <= value;
    else                        cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/rcn_uart_tx_byte.sv
// UART byte transmitter (8N1/8N2, LSB first) fed straight from a
// show-ahead byte FIFO. Back-to-back frames pop on the final stop cycle.
module rcn_uart_tx_byte
  import rcn_uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] divisor,
  input  logic             stop2,
  input  logic [7:0]       din,
  input  logic             empty,
  output logic             pop,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  uart_state_e            state_q, state_d;
  logic [DATA_BITS-1:0]   sh;
  logic [IDX_W-1:0]       idx;
  logic [DIV_W-1:0]       div_q;
  logic                   stop2_q;
  logic                   tick;
  logic                   frame_end;

  // A fresh frame takes the live divisor; all later bits use the latched copy.
  rcn_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (busy),
    .load  (pop),
    .value (pop ? divisor : div_q),
    .tick  (tick)
  );

  // Last cycle of the final stop bit (idx counts stop bits already sent).
  assign frame_end = (state_q == ST_STOP) && tick && (!stop2_q || idx == IDX_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && idx == IDX_W'(DATA_BITS - 1)) state_d = ST_STOP;
      ST_STOP:  if (frame_end) state_d = pop ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: pop only at the two frame-start points, never in reset.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = frame_end;
    pop  = !rst && en && !empty && ((state_q == ST_IDLE) || frame_end);
  end

  // Datapath: registered tx, shift register, bit index and frame settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      sh      <= '0;
      idx     <= '0;
      div_q   <= '0;
      stop2_q <= 1'b0;
    end else if (pop) begin
      tx      <= 1'b0;
      sh      <= din;
      idx     <= '0;
      div_q   <= divisor;
      stop2_q <= stop2;
    end else if (tick) begin
      case (state_q)
        ST_START: begin
          tx <= sh[0];
          sh <= sh >> 1;
        end
        ST_DATA: begin
          idx <= idx + 1'b1;
          if (idx == IDX_W'(DATA_BITS - 1)) tx <= 1'b1;
          else begin
            tx <= sh[0];
            sh <= sh >> 1;
          end
        end
        ST_STOP: begin
          idx <= idx + 1'b1;
          tx  <= 1'b1;
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
